// File: rtl/ahb_slave_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_slave_regbank
//  Purpose  : AHB-Lite slave register bank. Decodes address phases, performs
//             register reads and writes, and flags illegal accesses to the
//             downstream response generator through error_en.
//  Option   : AHB_REGBANK_ERR_LOG_EN builds the error counter/address log.
//             Without it, err_cnt and err_addr are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_slave_regbank #(
   parameter int ADDR_W  = 12,
   parameter int NREG    = 16,
   parameter int RO_BASE = 12
) (
   input  logic                          hclk,
   input  logic                          hreset,
   input  logic                          hsel,
   input  logic [1:0]                    htrans,
   input  logic [ADDR_W-1:0]             haddr,
   input  logic                          hwrite,
   input  logic [2:0]                    hsize,
   input  logic [31:0]                   hwdata,
   input  logic                          hready_in,
   input  logic [(NREG-RO_BASE)*32-1:0]  stat_in,
   input  logic                          err_clr,
   output logic [31:0]                   hrdata,
   output logic                          error_en,
   output logic [7:0]                    err_cnt,
   output logic [ADDR_W-1:0]             err_addr
);

   localparam int                IDX_W      = ADDR_W - 2;
   localparam int                RI_W       = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NREG * 4);
   localparam logic [IDX_W-1:0]  RO_IDX     = IDX_W'(RO_BASE);
   localparam logic [2:0]        SIZE_WORD  = 3'b010;

   logic [IDX_W-1:0] idx;
   logic [RI_W-1:0]  ridx;
   logic             acc;
   logic             illegal;
   logic             wr_ok;
   logic             rd_ok;
   logic             wr_commit;
   logic             wr_pend;
   logic [RI_W-1:0]  wr_idx;
   logic [31:0]      regs  [RO_BASE];
   logic [31:0]      words [NREG];
   logic [31:0]      rd_word;
   logic             unused_bits;

   assign idx  = haddr[ADDR_W-1:2];
   assign ridx = idx[RI_W-1:0];

   // Address-phase decode: only a selected NONSEQ/SEQ transfer on a ready bus counts.
   assign acc     = hsel & htrans[1] & hready_in;
   assign illegal = acc & ((haddr >= ADDR_LIMIT)     |
                           (haddr[1:0] != 2'b00)     |
                           (hsize != SIZE_WORD)      |
                           (hwrite & (idx >= RO_IDX)));
   assign wr_ok   = acc & ~illegal &  hwrite;
   assign rd_ok   = acc & ~illegal & ~hwrite;

   // Combinational so the response generator sees it in the address-phase cycle.
   assign error_en = illegal;

   // The pending write lands whenever the bus is ready during its data phase.
   assign wr_commit = wr_pend & hready_in;

   // Read view of the whole map: RW storage below RO_BASE, status words above.
   for (genvar i = 0; i < NREG; i++) begin : g_words
      if (i < RO_BASE) begin : g_rw
         assign words[i] = regs[i];
      end else begin : g_ro
         assign words[i] = stat_in[(i-RO_BASE)*32 +: 32];
      end
   end

   assign rd_word = words[ridx];

   // Write pipeline: capture the target index at accept, hold it until the data phase completes.
   always_ff @(posedge hclk or negedge hreset) begin
      if (!hreset) begin
         wr_pend <= 1'b0;
         wr_idx  <= '0;
      end else if (wr_ok) begin
         wr_pend <= 1'b1;
         wr_idx  <= ridx;
      end else if (wr_commit) begin
         wr_pend <= 1'b0;
      end
   end

   // Register storage: written from hwdata in the write data phase.
   always_ff @(posedge hclk or negedge hreset) begin
      if (!hreset) begin
         for (int i = 0; i < RO_BASE; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_commit) begin
         for (int i = 0; i < RO_BASE; i++) begin
            if (wr_idx == RI_W'(i)) begin
               regs[i] <= hwdata;
            end
         end
      end
   end

   // Read data: loaded at the accept edge, forwarded from hwdata when it targets the pending write.
   always_ff @(posedge hclk or negedge hreset) begin
      if (!hreset) begin
         hrdata <= '0;
      end else if (illegal) begin
         hrdata <= '0;
      end else if (rd_ok) begin
         hrdata <= (wr_pend && (wr_idx == ridx)) ? hwdata : rd_word;
      end
   end

`ifdef AHB_REGBANK_ERR_LOG_EN
   // Error log: saturating count and last offending address; a clear beats a new error.
   always_ff @(posedge hclk or negedge hreset) begin
      if (!hreset) begin
         err_cnt  <= '0;
         err_addr <= '0;
      end else if (err_clr) begin
         err_cnt  <= '0;
         err_addr <= '0;
      end else if (error_en) begin
         if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
         end
         err_addr <= haddr;
      end
   end

   assign unused_bits = htrans[0];
`else
   assign err_cnt     = '0;
   assign err_addr    = '0;
   assign unused_bits = htrans[0] ^ err_clr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_slave_regbank
//  Purpose  : Self-checking bench for ahb_slave_regbank. Read expectations
//             are queued at the address phase and compared in the data phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_regbank;

   localparam int         ADDR_W  = 12;
   localparam int         NREG    = 16;
   localparam int         RO_BASE = 12;
   localparam int         NRO     = NREG - RO_BASE;
   localparam logic [1:0] IDLE    = 2'b00;
   localparam logic [1:0] BUSY    = 2'b01;
   localparam logic [1:0] NONSEQ  = 2'b10;
   localparam logic [1:0] SEQ     = 2'b11;
   localparam logic [2:0] WORD    = 3'b010;

   logic              hclk = 1'b0;
   logic              hreset = 1'b0;
   logic              hsel = 1'b0;
   logic [1:0]        htrans = IDLE;
   logic [ADDR_W-1:0] haddr = '0;
   logic              hwrite = 1'b0;
   logic [2:0]        hsize = WORD;
   logic [31:0]       hwdata = '0;
   logic              hready_in = 1'b1;
   logic [NRO*32-1:0] stat_in = {32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000};
   logic              err_clr = 1'b0;
   logic [31:0]       hrdata;
   logic              error_en;
   logic [7:0]        err_cnt;
   logic [ADDR_W-1:0] err_addr;

   int                checks = 0;
   int                errors = 0;
   logic [31:0]       model_regs [NREG];
   logic [31:0]       exp_q [$];
   logic              pend;
   int                pend_idx;
   logic [31:0]       model_hrdata;
   int                model_cnt;
   logic [ADDR_W-1:0] model_eaddr;

   ahb_slave_regbank #(
      .ADDR_W  (ADDR_W),
      .NREG    (NREG),
      .RO_BASE (RO_BASE)
   ) dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .hsel      (hsel),
      .htrans    (htrans),
      .haddr     (haddr),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hwdata    (hwdata),
      .hready_in (hready_in),
      .stat_in   (stat_in),
      .err_clr   (err_clr),
      .hrdata    (hrdata),
      .error_en  (error_en),
      .err_cnt   (err_cnt),
      .err_addr  (err_addr)
   );

   always #5 hclk = ~hclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         model_regs[i] = '0;
      end
      pend         = 1'b0;
      pend_idx     = 0;
      model_hrdata = '0;
      model_cnt    = 0;
      model_eaddr  = '0;
      exp_q.delete();
   endtask

   // One bus cycle: address phase (sel/tr/a/wr/sz), hwdata for the previous write, bus ready.
   task automatic cyc(input string tag, input logic sel, input logic [1:0] tr,
                      input logic [ADDR_W-1:0] a, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wd, input logic rdy);
      logic acc;
      logic ill;
      int   ix;
      bit   pushed;
      hsel = sel; htrans = tr; haddr = a; hwrite = wr; hsize = sz; hwdata = wd; hready_in = rdy;
      #1;
      acc = sel & tr[1] & rdy;
      ix  = int'(a[ADDR_W-1:2]);
      ill = acc & ((a >= ADDR_W'(NREG*4)) | (a[1:0] != 2'b00) | (sz != WORD) |
                   (wr & (ix >= RO_BASE)));
      check({tag, " error_en"}, 32'(error_en), 32'(ill));
      if (pend && rdy) begin
         model_regs[pend_idx] = wd;
         pend = 1'b0;
      end
      pushed = 1'b0;
      if (ill) begin
         exp_q.push_back(32'h0);
         pushed = 1'b1;
      end else if (acc && wr) begin
         pend     = 1'b1;
         pend_idx = ix;
      end else if (acc) begin
         exp_q.push_back((ix >= RO_BASE) ? stat_in[(ix-RO_BASE)*32 +: 32] : model_regs[ix]);
         pushed = 1'b1;
      end
`ifdef AHB_REGBANK_ERR_LOG_EN
      if (err_clr) begin
         model_cnt   = 0;
         model_eaddr = '0;
      end else if (ill) begin
         if (model_cnt < 255) model_cnt++;
         model_eaddr = a;
      end
`endif
      @(posedge hclk);
      #1;
      if (pushed) model_hrdata = exp_q.pop_front();
      check({tag, " hrdata"}, hrdata, model_hrdata);
      check({tag, " err_cnt"}, 32'(err_cnt), 32'(model_cnt));
      check({tag, " err_addr"}, 32'(err_addr), 32'(model_eaddr));
   endtask

   // Idle cycles the response generator inserts after an illegal access.
   task automatic err_resp(input string tag);
      cyc({tag, " resp1"}, 1'b0, IDLE, '0, 1'b0, WORD, 32'h0, 1'b0);
      cyc({tag, " resp2"}, 1'b0, IDLE, '0, 1'b0, WORD, 32'h0, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #12;
      check("reset hrdata", hrdata, 32'h0);
      check("reset error_en", 32'(error_en), 32'h0);
      check("reset err_cnt", 32'(err_cnt), 32'h0);
      check("reset err_addr", 32'(err_addr), 32'h0);
      hreset = 1'b1;
      @(posedge hclk);
      #1;

      // Plain write then read
      cyc("wr004",  1'b1, NONSEQ, 12'h004, 1'b1, WORD, 32'h0,        1'b1);
      cyc("wr004d", 1'b0, IDLE,   12'h000, 1'b0, WORD, 32'hDEADBEEF, 1'b1);
      cyc("rd004",  1'b1, NONSEQ, 12'h004, 1'b0, WORD, 32'h0,        1'b1);
      cyc("idle1",  1'b0, IDLE,   12'h000, 1'b0, WORD, 32'h0,        1'b1);

      // Back-to-back write/read of the same word: forwarded
      cyc("wr008",  1'b1, NONSEQ, 12'h008, 1'b1, WORD, 32'h0,        1'b1);
      cyc("rd008f", 1'b1, NONSEQ, 12'h008, 1'b0, WORD, 32'h11223344, 1'b1);
      cyc("rd008",  1'b1, SEQ,    12'h008, 1'b0, WORD, 32'h0,        1'b1);

      // Back-to-back writes, the second keeps the pending slot
      cyc("wr00c",  1'b1, NONSEQ, 12'h00C, 1'b1, WORD, 32'h0,        1'b1);
      cyc("wr010",  1'b1, SEQ,    12'h010, 1'b1, WORD, 32'hA0A0A0A0, 1'b1);
      cyc("rd00c",  1'b1, NONSEQ, 12'h00C, 1'b0, WORD, 32'hB1B1B1B1, 1'b1);
      cyc("rd010",  1'b1, NONSEQ, 12'h010, 1'b0, WORD, 32'h0,        1'b1);

      // Write data phase stretched by hready_in=0
      cyc("wr014",  1'b1, NONSEQ, 12'h014, 1'b1, WORD, 32'h0,        1'b1);
      cyc("wr014w", 1'b1, NONSEQ, 12'h014, 1'b0, WORD, 32'hBAD0BAD0, 1'b0);
      cyc("wr014d", 1'b0, IDLE,   12'h000, 1'b0, WORD, 32'h600DF00D, 1'b1);
      cyc("rd014",  1'b1, NONSEQ, 12'h014, 1'b0, WORD, 32'h0,        1'b1);

      // Out-of-range read
      cyc("rd040",  1'b1, NONSEQ, 12'h040, 1'b0, WORD, 32'h0,        1'b1);
      err_resp("rd040");
      cyc("rd004b", 1'b1, NONSEQ, 12'h004, 1'b0, WORD, 32'h0,        1'b1);

      // Not accepted: hready_in low, hsel low, BUSY
      cyc("noacc_rdy",  1'b1, NONSEQ, 12'h040, 1'b0, WORD, 32'h0, 1'b0);
      cyc("noacc_sel",  1'b0, NONSEQ, 12'h041, 1'b1, WORD, 32'h0, 1'b1);
      cyc("noacc_busy", 1'b1, BUSY,   12'h030, 1'b1, 3'b001, 32'h0, 1'b1);

      // RO write, bad size, misaligned
      cyc("wr030",  1'b1, NONSEQ, 12'h030, 1'b1, WORD,   32'h0, 1'b1);
      err_resp("wr030");
      cyc("sz001",  1'b1, NONSEQ, 12'h000, 1'b1, 3'b001, 32'h0, 1'b1);
      err_resp("sz001");
      cyc("mis002", 1'b1, NONSEQ, 12'h002, 1'b0, WORD,   32'h0, 1'b1);
      err_resp("mis002");
      cyc("rd030",  1'b1, NONSEQ, 12'h030, 1'b0, WORD,   32'h0, 1'b1);
      cyc("rd03c",  1'b1, NONSEQ, 12'h03C, 1'b0, WORD,   32'h0, 1'b1);
      cyc("rd000",  1'b1, NONSEQ, 12'h000, 1'b0, WORD,   32'h0, 1'b1);

      // Saturation of the error counter
      for (int i = 0; i < 300; i++) begin
         cyc("sat", 1'b1, NONSEQ, 12'(64 + 4 * i), 1'b0, WORD, 32'h0, 1'b1);
         cyc("sat resp", 1'b0, IDLE, '0, 1'b0, WORD, 32'h0, 1'b0);
      end
      cyc("sat last", 1'b1, NONSEQ, 12'h044, 1'b0, WORD, 32'h0, 1'b1);
      err_clr = 1'b1;
      cyc("clr_err", 1'b1, NONSEQ, 12'h048, 1'b0, WORD, 32'h0, 1'b1);
      err_clr = 1'b0;
      err_resp("clr_err");
      cyc("post_clr", 1'b1, NONSEQ, 12'h04C, 1'b0, WORD, 32'h0, 1'b1);
      err_resp("post_clr");

      // Reset during a write data phase drops the write
      cyc("rd004c", 1'b1, NONSEQ, 12'h004, 1'b0, WORD, 32'h0, 1'b1);
      cyc("wr018",  1'b1, NONSEQ, 12'h018, 1'b1, WORD, 32'h0, 1'b1);
      hsel = 1'b0; htrans = IDLE; hwdata = 32'hCAFEF00D; hready_in = 1'b1;
      #2;
      hreset = 1'b0;
      #1;
      model_reset();
      check("rst_mid hrdata", hrdata, 32'h0);
      check("rst_mid err_cnt", 32'(err_cnt), 32'h0);
      check("rst_mid err_addr", 32'(err_addr), 32'h0);
      @(posedge hclk);
      #1;
      hreset = 1'b1;
      cyc("rd018", 1'b1, NONSEQ, 12'h018, 1'b0, WORD, 32'h0, 1'b1);
      cyc("rd004r", 1'b1, NONSEQ, 12'h004, 1'b0, WORD, 32'h0, 1'b1);
      cyc("idle_end", 1'b0, IDLE, 12'h000, 1'b0, WORD, 32'h0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
